// File: rtl/axi_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_pkg
// Description : Shared types and constants for the AXI burst splitter:
//               FSM state encoding, AXI INCR burst code, AXI size encoder
//               and the default address boundary that bursts may not cross.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam int         DEFAULT_BOUNDARY = 4096;

    // AXI AxSIZE encoding: log2 of bytes per beat.
    function automatic logic [2:0] size_encode(input int bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage : axi_burst_pkg
`default_nettype wire

// File: rtl/byte_strb_gen.sv
`default_nettype none
// ============================================================================
// Module      : byte_strb_gen
// Description : Combinational byte-lane mask generator for the first and last
//               beat of a burst.
//   i_off         : byte lane of the first valid byte in the first beat
//   i_last_lane   : byte lane of the last valid byte in the last beat
//   o_first_strb  : lanes i >= i_off
//   o_last_strb   : lanes i <= i_last_lane
// Revision    : 1.0 - initial release
// ============================================================================
module byte_strb_gen #(
    parameter int BYTES = 4,
    parameter int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic [OFF_W-1:0] i_off,
    input  logic [OFF_W-1:0] i_last_lane,
    output logic [BYTES-1:0] o_first_strb,
    output logic [BYTES-1:0] o_last_strb
);

    for (genvar i = 0; i < BYTES; i++) begin : g_lane
        assign o_first_strb[i] = (OFF_W'(i) >= i_off);
        assign o_last_strb[i]  = (OFF_W'(i) <= i_last_lane);
    end

endmodule : byte_strb_gen
`default_nettype wire

// File: rtl/axi_burst_splitter.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_splitter
// Description : Splits a (possibly misaligned) byte transfer into a sequence
//               of AXI INCR burst commands. Bursts never cross BOUNDARY and
//               never exceed MAX_BEATS beats. Each command carries first-beat
//               and last-beat byte strobes.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   start            : single-cycle start pulse
//   start_addr/bytes : transfer byte address and byte count (0 = no-op)
//   cmd_valid/ready  : burst command handshake
//   cmd_addr         : beat-aligned burst address
//   cmd_len          : AXI len (beats-1)
//   cmd_size/burst   : constant log2(BYTES) / INCR
//   cmd_first_strb   : valid lanes of first beat
//   cmd_last_strb    : valid lanes of last beat (consumer ANDs with
//                      first_strb when cmd_len==0)
//   busy             : transfer in progress
//   done             : one-cycle pulse after the final burst is accepted
//   start_err        : one-cycle pulse when start arrives while busy
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_splitter
    import axi_burst_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BEATS = 256,
    parameter int BOUNDARY  = DEFAULT_BOUNDARY
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [LEN_W-1:0]    start_bytes,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [ADDR_W-1:0]   cmd_addr,
    output logic [7:0]          cmd_len,
    output logic [2:0]          cmd_size,
    output logic [1:0]          cmd_burst,
    output logic [DATA_W/8-1:0] cmd_first_strb,
    output logic [DATA_W/8-1:0] cmd_last_strb,
    output logic                busy,
    output logic                done,
    output logic                start_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int OFF_W = (SZ > 0) ? SZ : 1;
    localparam int BND_W = $clog2(BOUNDARY);

    // Arithmetic width: wide enough for the byte count plus one bit, and for
    // the boundary span and the largest burst in bytes.
    localparam int CW_A  = LEN_W + 1;
    localparam int CW_B  = BND_W + 1;
    localparam int CW_C  = $clog2(MAX_BEATS * BYTES) + 1;
    localparam int CW_AB = (CW_A > CW_B) ? CW_A : CW_B;
    localparam int CW    = (CW_AB > CW_C) ? CW_AB : CW_C;

    localparam logic [CW-1:0]     C_BOUNDARY  = CW'(BOUNDARY);
    localparam logic [CW-1:0]     C_MAX_BYTES = CW'(MAX_BEATS * BYTES);
    localparam logic [CW-1:0]     C_BYTES_M1  = CW'(BYTES - 1);
    localparam logic [ADDR_W-1:0] C_ADDR_MASK = ~ADDR_W'(BYTES - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_rem;
    logic [CW-1:0]       r_bbytes;
    logic                r_cmd_valid;
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic [7:0]          r_cmd_len;
    logic [BYTES-1:0]    r_first_strb;
    logic [BYTES-1:0]    r_last_strb;
    logic                r_busy;
    logic                r_done;
    logic                r_start_err;

    // ------------------------------------------------------------------
    // Burst sizing (evaluated from the current address/remaining count)
    // ------------------------------------------------------------------
    logic [OFF_W-1:0]    w_off;
    logic [OFF_W-1:0]    w_last_lane;
    logic [CW-1:0]       w_off_ext;
    logic [CW-1:0]       w_to_bnd;
    logic [CW-1:0]       w_room;
    logic [CW-1:0]       w_bb;
    logic [CW-1:0]       w_end;
    logic [CW-1:0]       w_beats;
    logic [BYTES-1:0]    w_first_strb;
    logic [BYTES-1:0]    w_last_strb;
    logic                w_accept;
    logic                w_last_burst;
    logic                w_start_ok;

    if (SZ > 0) begin : g_off_lanes
        assign w_off       = r_addr[SZ-1:0];
        assign w_last_lane = OFF_W'(w_end - CW'(1));
    end else begin : g_off_single
        assign w_off       = 1'b0;
        assign w_last_lane = 1'b0;
    end

    assign w_off_ext = CW'(w_off);
    assign w_to_bnd  = C_BOUNDARY - CW'(r_addr[BND_W-1:0]);
    assign w_room    = C_MAX_BYTES - w_off_ext;

    always_comb begin
        w_bb = CW'(r_rem);
        if (w_to_bnd < w_bb) begin
            w_bb = w_to_bnd;
        end
        if (w_room < w_bb) begin
            w_bb = w_room;
        end
        w_end   = w_off_ext + w_bb;
        w_beats = (w_end + C_BYTES_M1) >> SZ;
    end

    byte_strb_gen #(
        .BYTES (BYTES),
        .OFF_W (OFF_W)
    ) u_strb (
        .i_off        (w_off),
        .i_last_lane  (w_last_lane),
        .o_first_strb (w_first_strb),
        .o_last_strb  (w_last_strb)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign w_accept     = (r_state == ST_ISSUE) && cmd_ready;
    assign w_last_burst = (CW'(r_rem) == r_bbytes);
    assign w_start_ok   = (r_state == ST_IDLE) && start;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (start_bytes != '0) ? ST_CALC : ST_DONE;
                end
            end
            ST_CALC: begin
                w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    w_state_nxt = w_last_burst ? ST_DONE : ST_CALC;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr       <= '0;
            r_rem        <= '0;
            r_bbytes     <= '0;
            r_cmd_valid  <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_len    <= '0;
            r_first_strb <= '0;
            r_last_strb  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_start_err  <= 1'b0;
        end else begin
            r_start_err <= start && (r_state != ST_IDLE);
            r_done      <= (r_state == ST_DONE);
            r_busy      <= (w_state_nxt != ST_IDLE);

            if (w_start_ok && (start_bytes != '0)) begin
                r_addr <= start_addr;
                r_rem  <= start_bytes;
            end

            if (r_state == ST_CALC) begin
                r_cmd_valid  <= 1'b1;
                r_bbytes     <= w_bb;
                r_cmd_addr   <= r_addr & C_ADDR_MASK;
                r_cmd_len    <= 8'(w_beats - CW'(1));
                r_first_strb <= w_first_strb;
                r_last_strb  <= w_last_strb;
            end

            if (w_accept) begin
                r_cmd_valid <= 1'b0;
                r_addr      <= r_addr + ADDR_W'(r_bbytes);
                r_rem       <= r_rem - LEN_W'(r_bbytes);
            end
        end
    end

    assign cmd_valid      = r_cmd_valid;
    assign cmd_addr       = r_cmd_addr;
    assign cmd_len        = r_cmd_len;
    assign cmd_size       = size_encode(BYTES);
    assign cmd_burst      = AXI_BURST_INCR;
    assign cmd_first_strb = r_first_strb;
    assign cmd_last_strb  = r_last_strb;
    assign busy           = r_busy;
    assign done           = r_done;
    assign start_err      = r_start_err;

endmodule : axi_burst_splitter
`default_nettype wire

// File: tb/tb_axi_burst_splitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_burst_splitter
// Description : Directed self-checking bench for axi_burst_splitter
//               (DATA_W=32, 4 KB boundary, 256 max beats).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_burst_splitter;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [31:0] start_addr;
    logic [15:0] start_bytes;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [3:0]  cmd_first_strb;
    logic [3:0]  cmd_last_strb;
    logic        busy;
    logic        done;
    logic        start_err;

    int n_vec;
    int n_miss;

    axi_burst_splitter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .LEN_W     (16),
        .MAX_BEATS (256),
        .BOUNDARY  (4096)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start),
        .start_addr     (start_addr),
        .start_bytes    (start_bytes),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_size       (cmd_size),
        .cmd_burst      (cmd_burst),
        .cmd_first_strb (cmd_first_strb),
        .cmd_last_strb  (cmd_last_strb),
        .busy           (busy),
        .done           (done),
        .start_err      (start_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start pulse driven for exactly one rising edge; returns at the
    // falling edge just after the edge that sampled it.
    task automatic pulse_start(input logic [31:0] a, input logic [15:0] b);
        @(negedge clk);
        start       = 1'b1;
        start_addr  = a;
        start_bytes = b;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!cmd_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_valid) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic check_cmd(input string tag, input logic [31:0] a, input logic [7:0] l,
                             input logic [3:0] fs, input logic [3:0] ls);
        chk({tag, "_valid"}, 64'(cmd_valid), 64'd1);
        chk({tag, "_addr"},  64'(cmd_addr), 64'(a));
        chk({tag, "_len"},   64'(cmd_len), 64'(l));
        chk({tag, "_first"}, 64'(cmd_first_strb), 64'(fs));
        chk({tag, "_last"},  64'(cmd_last_strb), 64'(ls));
    endtask

    task automatic accept;
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        rstn        = 1'b0;
        start       = 1'b0;
        start_addr  = '0;
        start_bytes = '0;
        cmd_ready   = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(cmd_valid), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_err",   64'(start_err), 64'd0);
        chk("rst_addr",  64'(cmd_addr), 64'd0);
        chk("rst_len",   64'(cmd_len), 64'd0);
        chk("rst_strb",  64'({cmd_first_strb, cmd_last_strb}), 64'd0);
        chk("rst_size",  64'(cmd_size), 64'd2);
        chk("rst_burst", 64'(cmd_burst), 64'd1);
        rstn = 1'b1;
        @(negedge clk);

        // ---------------- aligned single burst ----------------
        pulse_start(32'h1000, 16'd16);
        chk("al_busy", 64'(busy), 64'd1);
        chk("al_lat1", 64'(cmd_valid), 64'd0);
        @(negedge clk);
        check_cmd("al", 32'h1000, 8'd3, 4'hF, 4'hF);
        chk("al_size",  64'(cmd_size), 64'd2);
        chk("al_burst", 64'(cmd_burst), 64'd1);
        accept();
        chk("al_vdrop", 64'(cmd_valid), 64'd0);
        chk("al_done0", 64'(done), 64'd0);
        @(negedge clk);
        chk("al_done",  64'(done), 64'd1);
        chk("al_idle",  64'(busy), 64'd0);
        @(negedge clk);
        chk("al_done_1cyc", 64'(done), 64'd0);

        // ---------------- misaligned single burst ----------------
        pulse_start(32'h1003, 16'd6);
        wait_valid("mis");
        check_cmd("mis", 32'h1000, 8'd2, 4'h8, 4'h1);
        accept();
        @(negedge clk);
        chk("mis_done", 64'(done), 64'd1);

        // ---------------- 4 KB crossing ----------------
        pulse_start(32'h0FFA, 16'd12);
        wait_valid("x1");
        check_cmd("x1", 32'h0FF8, 8'd1, 4'hC, 4'hF);
        accept();
        chk("x_gap", 64'(cmd_valid), 64'd0);
        @(negedge clk);
        check_cmd("x2", 32'h1000, 8'd1, 4'hF, 4'h3);
        chk("x2_busy", 64'(busy), 64'd1);
        accept();
        @(negedge clk);
        chk("x_done", 64'(done), 64'd1);

        // ---------------- max-beat split ----------------
        pulse_start(32'h0, 16'd2048);
        wait_valid("mb1");
        check_cmd("mb1", 32'h0, 8'd255, 4'hF, 4'hF);
        accept();
        wait_valid("mb2");
        check_cmd("mb2", 32'h400, 8'd255, 4'hF, 4'hF);
        accept();
        chk("mb_nodone", 64'(done), 64'd0);
        @(negedge clk);
        chk("mb_done", 64'(done), 64'd1);
        chk("mb_after", 64'(cmd_valid), 64'd0);

        // ---------------- backpressure and overlapping start ----------------
        pulse_start(32'h0FFA, 16'd12);
        wait_valid("bp");
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                start       = 1'b1;
                start_addr  = 32'h8000;
                start_bytes = 16'd64;
            end
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                chk("bp_err", 64'(start_err), 64'd1);
            end
            if (c == 2) chk("bp_err_1cyc", 64'(start_err), 64'd0);
            chk("bp_hold_addr", 64'(cmd_addr), 64'h0FF8);
            chk("bp_hold_len",  64'(cmd_len), 64'd1);
            chk("bp_hold_strb", 64'({cmd_first_strb, cmd_last_strb}), 64'hCF);
            chk("bp_hold_v",    64'(cmd_valid), 64'd1);
        end
        accept();
        wait_valid("bp2");
        check_cmd("bp2", 32'h1000, 8'd1, 4'hF, 4'h3);
        accept();
        // start during the DONE cycle is rejected
        start       = 1'b1;
        start_addr  = 32'h4000;
        start_bytes = 16'd4;
        @(negedge clk);
        start = 1'b0;
        chk("dn_done", 64'(done), 64'd1);
        chk("dn_err",  64'(start_err), 64'd1);
        repeat (3) @(negedge clk);
        chk("dn_ignored", 64'(cmd_valid), 64'd0);
        chk("dn_idle",    64'(busy), 64'd0);

        // ---------------- zero length ----------------
        pulse_start(32'h1234, 16'd0);
        chk("z_busy", 64'(busy), 64'd1);
        chk("z_done0", 64'(done), 64'd0);
        @(negedge clk);
        chk("z_done", 64'(done), 64'd1);
        chk("z_novalid", 64'(cmd_valid), 64'd0);
        chk("z_idle", 64'(busy), 64'd0);

        // ---------------- reset during ISSUE ----------------
        pulse_start(32'h2000, 16'd8);
        wait_valid("rs");
        #2;
        rstn = 1'b0;
        #1;
        chk("rs_valid", 64'(cmd_valid), 64'd0);
        chk("rs_busy",  64'(busy), 64'd0);
        chk("rs_addr",  64'(cmd_addr), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        pulse_start(32'h3001, 16'd3);
        wait_valid("rs2");
        check_cmd("rs2", 32'h3000, 8'd0, 4'hE, 4'hF);
        accept();
        @(negedge clk);
        chk("rs2_done", 64'(done), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_axi_burst_splitter
`default_nettype wire
